vga_timing_gen: RTL and testbench

Parametrised, runtime-reconfigurable raster timing generator that drives the display sync, enable and coordinate signals for the video output path. It generalises the fixed 800x600 controller in three ways:
- Timing is loaded through a valid/ready config port and applied glitch-free at a frame boundary.
- A pixel-request stream runs a configurable number of cycles ahead of the display outputs, hiding pixel-source latency.
- It adds frame and line strobes.

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable raster timing generator. A shadow config is swapped in
// at the frame boundary; request outputs lead display outputs by PIPE_LAT cycles.
module vga_timing_gen #(
    parameter int CW       = 12,
    parameter int PIPE_LAT = 2,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_h_pol,
    input  logic          cfg_v_pol,
    output logic          cfg_err,
    output logic          cfg_pending,
    output logic          req_valid,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          h_sync,
    output logic          v_sync,
    output logic          disp_enbl,
    output logic [CW-1:0] h_coord,
    output logic [CW-1:0] v_coord,
    output logic          frame_start,
    output logic          line_start
);
    typedef logic [CW+1:0] wide_t;

    typedef struct packed {
        logic [CW-1:0] ha, hfp, hs, hbp, va, vfp, vs, vbp;
        logic          hp, vp;
    } timing_t;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] x, y;
        logic          hs, vs, ls, fs;
    } stage_t;

    localparam timing_t DEF = '{ha: CW'(H_ACTIVE), hfp: CW'(H_FP), hs: CW'(H_SYNC), hbp: CW'(H_BP),
                                va: CW'(V_ACTIVE), vfp: CW'(V_FP), vs: CW'(V_SYNC), vbp: CW'(V_BP),
                                hp: 1'(H_POL), vp: 1'(V_POL)};
    localparam stage_t RST_ST = '{vld: 1'b0, x: '0, y: '0, hs: ~1'(H_POL), vs: ~1'(V_POL),
                                  ls: 1'b0, fs: 1'b0};
    localparam wide_t MAXT = {2'b01, {CW{1'b0}}};

    function automatic wide_t ext(input logic [CW-1:0] a);
        return {2'b00, a};
    endfunction

    function automatic wide_t tot(input logic [CW-1:0] a, b, c, d);
        return ext(a) + ext(b) + ext(c) + ext(d);
    endfunction

    timing_t       cur_q, sh_q, cfg_t;
    logic          pend_q, err_q;
    logic [CW-1:0] h_cnt_q, v_cnt_q, h_cnt_d, v_cnt_d;
    stage_t        s0_d;
    stage_t        pipe_q [PIPE_LAT+1];

    wide_t ht, vt, hx, vy, h_ss, v_ss;
    logic  cfg_bad, h_last, v_last, apply;

    assign cfg_t = '{ha: cfg_h_active, hfp: cfg_h_fp, hs: cfg_h_sync, hbp: cfg_h_bp,
                     va: cfg_v_active, vfp: cfg_v_fp, vs: cfg_v_sync, vbp: cfg_v_bp,
                     hp: cfg_h_pol, vp: cfg_v_pol};

    assign cfg_bad = (cfg_h_active == '0) || (cfg_h_sync == '0) ||
                     (cfg_v_active == '0) || (cfg_v_sync == '0) ||
                     (tot(cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp) > MAXT) ||
                     (tot(cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp) > MAXT);

    assign ht     = tot(cur_q.ha, cur_q.hfp, cur_q.hs, cur_q.hbp);
    assign vt     = tot(cur_q.va, cur_q.vfp, cur_q.vs, cur_q.vbp);
    assign hx     = ext(h_cnt_q);
    assign vy     = ext(v_cnt_q);
    assign h_last = (hx == ht - wide_t'(1));
    assign v_last = (vy == vt - wide_t'(1));
    assign apply  = h_last && v_last && pend_q;
    assign h_ss   = ext(cur_q.ha) + ext(cur_q.hfp);
    assign v_ss   = ext(cur_q.va) + ext(cur_q.vfp);

    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        // Stage-0 terms use the timing in force for this counter value, polarity included.
        s0_d     = RST_ST;
        s0_d.vld = (hx < ext(cur_q.ha)) && (vy < ext(cur_q.va));
        s0_d.x   = h_cnt_q;
        s0_d.y   = v_cnt_q;
        s0_d.hs  = ((hx >= h_ss) && (hx < h_ss + ext(cur_q.hs))) ? cur_q.hp : ~cur_q.hp;
        s0_d.vs  = ((vy >= v_ss) && (vy < v_ss + ext(cur_q.vs))) ? cur_q.vp : ~cur_q.vp;
        s0_d.ls  = (h_cnt_q == '0);
        s0_d.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            cur_q   <= DEF;
            sh_q    <= DEF;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i <= PIPE_LAT; i++) pipe_q[i] <= RST_ST;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            err_q   <= 1'b0;
            // Handshake needs an empty shadow and apply needs a full one, so they never collide.
            if (cfg_valid && !pend_q) begin
                if (cfg_bad) begin
                    err_q <= 1'b1;
                end else begin
                    sh_q   <= cfg_t;
                    pend_q <= 1'b1;
                end
            end
            if (apply) begin
                cur_q  <= sh_q;
                pend_q <= 1'b0;
            end
            pipe_q[0] <= s0_d;
            for (int i = 1; i <= PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign cfg_ready   = ~pend_q;
    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;
    assign req_valid   = pipe_q[0].vld;
    assign req_x       = pipe_q[0].x;
    assign req_y       = pipe_q[0].y;
    assign disp_enbl   = pipe_q[PIPE_LAT].vld;
    assign h_coord     = pipe_q[PIPE_LAT].x;
    assign v_coord     = pipe_q[PIPE_LAT].y;
    assign h_sync      = pipe_q[PIPE_LAT].hs;
    assign v_sync      = pipe_q[PIPE_LAT].vs;
    assign line_start  = pipe_q[PIPE_LAT].ls;
    assign frame_start = pipe_q[PIPE_LAT].fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small raster (16x8 default, 12x8 reconfig),
// with a second PIPE_LAT=5 instance sharing the inputs.
module tb_vga_timing_gen;
    localparam int CW = 6;
    localparam int L  = 2;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0;
    logic [CW-1:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [CW-1:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic          cfg_h_pol = 1'b0, cfg_v_pol = 1'b0;

    logic          cfg_ready, cfg_err, cfg_pending, req_valid, h_sync, v_sync, disp_enbl;
    logic          frame_start, line_start;
    logic [CW-1:0] req_x, req_y, h_coord, v_coord;
    logic          cfg_ready5, cfg_err5, cfg_pending5, req_valid5, h_sync5, v_sync5, disp_enbl5;
    logic          frame_start5, line_start5;
    logic [CW-1:0] req_x5, req_y5, h_coord5, v_coord5;

    vga_timing_gen #(.CW(CW), .PIPE_LAT(L), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1)) u_dut (
        .pixel_clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol), .cfg_err(cfg_err), .cfg_pending(cfg_pending),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .h_sync(h_sync), .v_sync(v_sync),
        .disp_enbl(disp_enbl), .h_coord(h_coord), .v_coord(v_coord),
        .frame_start(frame_start), .line_start(line_start));

    vga_timing_gen #(.CW(CW), .PIPE_LAT(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1)) u_dut5 (
        .pixel_clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready5),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol), .cfg_err(cfg_err5), .cfg_pending(cfg_pending5),
        .req_valid(req_valid5), .req_x(req_x5), .req_y(req_y5), .h_sync(h_sync5), .v_sync(v_sync5),
        .disp_enbl(disp_enbl5), .h_coord(h_coord5), .v_coord(v_coord5),
        .frame_start(frame_start5), .line_start(line_start5));

    always #5 clk = ~clk;

    int            n_chk = 0, n_pass = 0;
    int            cyc = 0, last_fs = 0, fs_period = 0, align_err = 0;
    logic [CW-1:0] hx [5];
    logic          hv [5];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock; samples 1ns after the edge and checks both display pipes against request history.
    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (rst_n) begin
            if (h_coord !== hx[L-1] || disp_enbl !== hv[L-1] ||
                h_coord5 !== hx[4] || disp_enbl5 !== hv[4] ||
                req_x5 !== req_x || req_valid5 !== req_valid) align_err++;
        end
        for (int k = 4; k > 0; k--) begin
            hx[k] = hx[k-1];
            hv[k] = hv[k-1];
        end
        hx[0] = rst_n ? req_x : '0;
        hv[0] = rst_n ? req_valid : 1'b0;
        if (frame_start) begin
            fs_period = cyc - last_fs;
            last_fs   = cyc;
        end
    endtask

    task automatic send_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input logic ph, pv);
        @(negedge clk);
        cfg_h_active = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_sync = CW'(hs); cfg_h_bp = CW'(hb);
        cfg_v_active = CW'(va); cfg_v_fp = CW'(vf); cfg_v_sync = CW'(vs); cfg_v_bp = CW'(vb);
        cfg_h_pol = ph; cfg_v_pol = pv;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Measures one frame from a frame_start to the next; prev is the period that just ended.
    task automatic run_frame(input logic ph, pv, output int prev, per, en, hsn, hsx, vsn, vsy,
                             lsn, output logic hs0);
        int t = 0;
        while (!frame_start && t < 400) begin
            tick();
            t++;
        end
        chk("fs_found", int'(frame_start), 1);
        prev = fs_period;
        hs0 = h_sync;
        per = 0; en = 0; hsn = 0; vsn = 0; lsn = 0; hsx = -1; vsy = -1;
        do begin
            if (disp_enbl) en++;
            if (h_sync == ph) begin hsn++; if (hsx < 0) hsx = int'(h_coord); end
            if (v_sync == pv) begin vsn++; if (vsy < 0) vsy = int'(v_coord); end
            if (line_start) lsn++;
            tick();
            per++;
        end while (!frame_start && per < 400);
    endtask

    int   prev, per, en, hsn, hsx, vsn, vsy, lsn;
    logic hs0;

    initial begin
        for (int k = 0; k < 5; k++) begin hx[k] = '0; hv[k] = 1'b0; end
        repeat (3) tick();
        chk("rst_req_valid", int'(req_valid), 0);
        chk("rst_disp_enbl", int'(disp_enbl), 0);
        chk("rst_h_sync", int'(h_sync), 0);
        chk("rst_v_sync", int'(v_sync), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_cfg_pending", int'(cfg_pending), 0);
        chk("rst_frame_start", int'(frame_start), 0);

        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("e1_req_valid", int'(req_valid), 1);
        chk("e1_req_x", int'(req_x), 0);
        chk("e1_disp_enbl", int'(disp_enbl), 0);
        tick();
        chk("e2_req_x", int'(req_x), 1);
        chk("e2_disp_enbl", int'(disp_enbl), 0);
        tick();
        chk("e3_disp_enbl", int'(disp_enbl), 1);
        chk("e3_frame_start", int'(frame_start), 1);
        chk("e3_h_coord", int'(h_coord), 0);

        // Default 16x8 frame: h sync [10,13), v sync lines [5,7), active 8x4.
        run_frame(1'b1, 1'b1, prev, per, en, hsn, hsx, vsn, vsy, lsn, hs0);
        chk("def_period", per, 128);
        chk("def_enbl", en, 32);
        chk("def_hs_cnt", hsn, 24);
        chk("def_hs_x", hsx, 10);
        chk("def_vs_cnt", vsn, 32);
        chk("def_vs_y", vsy, 5);
        chk("def_lines", lsn, 8);
        chk("def_hs_at_fs", int'(hs0), 0);

        repeat (20) tick();
        send_cfg(6, 1, 2, 3, 3, 2, 1, 2, 1'b0, 1'b0);
        chk("acc_pending", int'(cfg_pending), 1);
        chk("acc_ready", int'(cfg_ready), 0);
        chk("acc_err", int'(cfg_err), 0);
        send_cfg(10, 1, 1, 1, 4, 1, 1, 1, 1'b1, 1'b1);
        chk("dup_pending", int'(cfg_pending), 1);
        chk("dup_err", int'(cfg_err), 0);

        // New 12x8 frame, negative sync: h sync [7,9), v sync line 5, active 6x3.
        run_frame(1'b0, 1'b0, prev, per, en, hsn, hsx, vsn, vsy, lsn, hs0);
        chk("old_frame_period", prev, 128);
        chk("new_period", per, 96);
        chk("new_enbl", en, 18);
        chk("new_hs_cnt", hsn, 16);
        chk("new_hs_x", hsx, 7);
        chk("new_vs_cnt", vsn, 12);
        chk("new_vs_y", vsy, 5);
        chk("new_hs_at_fs", int'(hs0), 1);
        chk("applied_pending", int'(cfg_pending), 0);
        chk("applied_ready", int'(cfg_ready), 1);

        send_cfg(0, 1, 2, 3, 3, 2, 1, 2, 1'b1, 1'b1);
        chk("rej0_err", int'(cfg_err), 1);
        chk("rej0_pending", int'(cfg_pending), 0);
        chk("rej0_ready", int'(cfg_ready), 1);
        tick();
        chk("rej0_err_drop", int'(cfg_err), 0);
        send_cfg(60, 2, 2, 2, 3, 2, 1, 2, 1'b1, 1'b1);
        chk("rej_tot_err", int'(cfg_err), 1);
        chk("rej_tot_pending", int'(cfg_pending), 0);
        run_frame(1'b0, 1'b0, prev, per, en, hsn, hsx, vsn, vsy, lsn, hs0);
        chk("unchanged_period", per, 96);

        send_cfg(58, 2, 2, 2, 3, 2, 1, 2, 1'b1, 1'b1);
        chk("max_tot_pending", int'(cfg_pending), 1);
        chk("max_tot_err", int'(cfg_err), 0);
        repeat (5) tick();
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", int'(req_valid), 0);
        chk("mid_rst_disp_enbl", int'(disp_enbl), 0);
        chk("mid_rst_pending", int'(cfg_pending), 0);
        chk("mid_rst_ready", int'(cfg_ready), 1);
        chk("mid_rst_h_sync", int'(h_sync), 0);
        chk("mid_rst_req_x", int'(req_x), 0);
        repeat (6) tick();
        @(negedge clk) rst_n = 1'b1;
        run_frame(1'b1, 1'b1, prev, per, en, hsn, hsx, vsn, vsy, lsn, hs0);
        chk("post_rst_period", per, 128);
        chk("post_rst_enbl", en, 32);
        chk("post_rst_hs_x", hsx, 10);
        chk("post_rst_pending", int'(cfg_pending), 0);
        chk("pipe_align", align_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
